ctrl_wr_capture: RTL and testbench

Write-data capture block on the memory side of the DDR path. It receives a write burst driven onto DQ/DQS by the controller and checks the DQS preamble, toggle and postamble. It assembles the burst beats into one data word and presents it with a single-cycle valid pulse. It is the receiving counterpart of the read-data driver, and uses the same beat order (byte 0 first) and the same DQS framing.

---
 rtl/ddr_pkg.sv | 30 +++
 rtl/dqs_frame_check.sv | 23 ++
 rtl/ctrl_wr_capture.sv | 135 +++++++++++++
 tb/tb_ctrl_wr_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared DDR write-path definitions: burst/preamble limits, capture FSM states
// and normalisation of the per-burst parameters latched on wr_start.
package ddr_pkg;

   localparam int BC4     = 4;
   localparam int BL8     = 8;
   localparam int PRE_MIN = 1;
   localparam int PRE_MAX = 2;
   localparam int BEAT_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      LATENCY,
      PREAMBLE,
      BURST,
      POSTAMBLE
   } ctrl_wr_cap_state_e;

   // Anything that is not BC4 runs as a full BL8 burst.
   function automatic logic [3:0] norm_bl(input logic [3:0] bl);
      return (bl == 4'(BC4)) ? 4'(BC4) : 4'(BL8);
   endfunction

   function automatic logic [1:0] norm_pre(input logic [1:0] pre);
      if (pre < 2'(PRE_MIN)) return 2'(PRE_MIN);
      if (pre > 2'(PRE_MAX)) return 2'(PRE_MAX);
      return pre;
   endfunction

endpackage

// File: rtl/dqs_frame_check.sv
// Expected DQS framing per capture phase; flags any strobe that disagrees
// with the preamble / beat-toggle / postamble pattern.
module dqs_frame_check
   import ddr_pkg::*;
(
   input  ctrl_wr_cap_state_e i_state,
   input  logic               i_beat_odd,
   input  logic               i_dqs_t,
   input  logic               i_dqs_c,
   output logic               o_mismatch
);

   always_comb begin
      o_mismatch = 1'b0;
      case (i_state)
         PREAMBLE:  o_mismatch = !(i_dqs_t && !i_dqs_c);
         BURST:     o_mismatch = (i_dqs_t != i_beat_odd) || (i_dqs_c != !i_beat_odd);
         POSTAMBLE: o_mismatch = !i_dqs_c;
         default:   o_mismatch = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_wr_capture.sv
// Memory-side write-burst capture: waits out CWL, checks DQS framing and
// assembles the beats (byte 0 first) into one word with a one-cycle valid.
module ctrl_wr_capture
   import ddr_pkg::*;
#(
   parameter int DQ_W   = 8,
   parameter int MAX_BL = 8,
   parameter int CWL_W  = 5
) (
   input  logic                     CK_t,
   input  logic                     reset_n,
   input  logic                     wr_start,
   input  logic [CWL_W-1:0]         cwl,
   input  logic [3:0]               burst_length,
   input  logic [1:0]               preamble,
   input  logic [DQ_W-1:0]          dq,
   input  logic                     dqs_t,
   input  logic                     dqs_c,
   output logic [DQ_W*MAX_BL-1:0]   wr_data,
   output logic                     wr_valid,
   output logic                     busy,
   output logic                     dqs_err,
   output logic                     overrun_err
);

   ctrl_wr_cap_state_e r_state;
   ctrl_wr_cap_state_e w_state_next;

   logic [CWL_W-1:0]  r_cwl;
   logic [3:0]        r_bl;
   logic [1:0]        r_pre;
   logic [CWL_W-1:0]  r_lat_cnt;
   logic [1:0]        r_pre_cnt;
   logic [BEAT_W-1:0] r_beat_cnt;
   logic              r_wr_valid;
   logic              r_dqs_err;
   logic              r_overrun;
   logic [DQ_W-1:0]   r_lane [MAX_BL];

   logic w_start_ok;
   logic w_capture;
   logic w_beat_last;
   logic w_mismatch;

   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_start_ok   = 1'b0;
      w_capture    = 1'b0;
      w_beat_last  = 1'b0;
      case (r_state)
         IDLE: begin
            if (wr_start) begin
               w_start_ok   = 1'b1;
               w_state_next = (cwl == '0) ? PREAMBLE : LATENCY;
            end
         end
         LATENCY: begin
            if (r_lat_cnt == r_cwl - CWL_W'(1)) w_state_next = PREAMBLE;
         end
         PREAMBLE: begin
            if (r_pre_cnt == r_pre - 2'd1) w_state_next = BURST;
         end
         BURST: begin
            w_capture   = 1'b1;
            w_beat_last = (r_beat_cnt == r_bl - 4'd1);
            if (w_beat_last) w_state_next = POSTAMBLE;
         end
         POSTAMBLE: w_state_next = IDLE;
         default:   w_state_next = IDLE;
      endcase
   end

   dqs_frame_check u_frame_check (
      .i_state    (r_state),
      .i_beat_odd (r_beat_cnt[0]),
      .i_dqs_t    (dqs_t),
      .i_dqs_c    (dqs_c),
      .o_mismatch (w_mismatch)
   );

   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         r_cwl      <= '0;
         r_bl       <= '0;
         r_pre      <= '0;
         r_lat_cnt  <= '0;
         r_pre_cnt  <= '0;
         r_beat_cnt <= '0;
         r_wr_valid <= 1'b0;
         r_dqs_err  <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_start_ok) begin
            r_cwl      <= cwl;
            r_bl       <= norm_bl(burst_length);
            r_pre      <= norm_pre(preamble);
            r_lat_cnt  <= '0;
            r_pre_cnt  <= '0;
            r_beat_cnt <= '0;
            r_dqs_err  <= 1'b0;
         end else begin
            if (r_state == LATENCY)  r_lat_cnt  <= r_lat_cnt + CWL_W'(1);
            if (r_state == PREAMBLE) r_pre_cnt  <= r_pre_cnt + 2'd1;
            if (w_capture)           r_beat_cnt <= r_beat_cnt + 4'd1;
            if (w_mismatch)          r_dqs_err  <= 1'b1;
         end
         r_wr_valid <= w_beat_last;
         r_overrun  <= wr_start && (r_state != IDLE);
      end
   end

   // Each lane is cleared on an accepted start, so short bursts leave upper lanes zero.
   for (genvar gi = 0; gi < MAX_BL; gi++) begin : g_lane
      always_ff @(posedge CK_t or negedge reset_n) begin
         if (!reset_n)
            r_lane[gi] <= '0;
         else if (w_start_ok)
            r_lane[gi] <= '0;
         else if (w_capture && (r_beat_cnt == BEAT_W'(gi)))
            r_lane[gi] <= dq;
      end
      assign wr_data[gi*DQ_W +: DQ_W] = r_lane[gi];
   end

   assign wr_valid    = r_wr_valid;
   assign busy        = (r_state != IDLE);
   assign dqs_err     = r_dqs_err;
   assign overrun_err = r_overrun;

endmodule

// File: tb/tb_ctrl_wr_capture.sv
// Directed and randomized write bursts against a transaction-level model that
// derives expected outputs from each burst's start edge and C/P/B timing.
module tb_ctrl_wr_capture;

   logic        CK_t = 1'b0;
   logic        reset_n;
   logic        wr_start;
   logic [4:0]  cwl;
   logic [3:0]  burst_length;
   logic [1:0]  preamble;
   logic [7:0]  dq;
   logic        dqs_t;
   logic        dqs_c;
   logic [63:0] wr_data;
   logic        wr_valid;
   logic        busy;
   logic        dqs_err;
   logic        overrun_err;

   always #5 CK_t = ~CK_t;

   ctrl_wr_capture #(.DQ_W(8), .MAX_BL(8), .CWL_W(5)) dut (
      .CK_t         (CK_t),
      .reset_n      (reset_n),
      .wr_start     (wr_start),
      .cwl          (cwl),
      .burst_length (burst_length),
      .preamble     (preamble),
      .dq           (dq),
      .dqs_t        (dqs_t),
      .dqs_c        (dqs_c),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .busy         (busy),
      .dqs_err      (dqs_err),
      .overrun_err  (overrun_err)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int n_fail = 0;

   // model state
   int          k = 0;
   bit          m_active = 0;
   int          m_s, m_c, m_p, m_b;
   logic [63:0] m_data = '0;
   bit          m_err = 0;
   int          n_ovr = 0;
   int          valid_rel = -1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge: model reacts to the inputs the DUT sampled, then outputs are compared.
   task automatic tick();
      bit   busy_before, v_exp, ov_exp;
      int   r, i;
      logic odd;
      @(posedge CK_t);
      k++;
      busy_before = m_active;
      v_exp  = 0;
      ov_exp = 0;
      if (m_active) begin
         r = k - m_s;
         if (r > m_c && r <= m_c + m_p) begin
            if (!(dqs_t == 1'b1 && dqs_c == 1'b0)) m_err = 1;
         end else if (r > m_c + m_p && r <= m_c + m_p + m_b) begin
            i   = r - m_c - m_p - 1;
            odd = i[0];
            if (dqs_t != odd || dqs_c != !odd) m_err = 1;
            m_data[8*i +: 8] = dq;
            if (i == m_b - 1) v_exp = 1;
         end else if (r == m_c + m_p + m_b + 1) begin
            if (dqs_c != 1'b1) m_err = 1;
            m_active = 0;
         end
      end
      if (wr_start) begin
         if (busy_before) ov_exp = 1;
         else begin
            m_active = 1;
            m_s      = k;
            m_c      = int'(cwl);
            m_b      = (burst_length == 4'd4) ? 4 : 8;
            m_p      = (preamble == 2'd0) ? 1 : ((preamble == 2'd3) ? 2 : int'(preamble));
            m_data   = '0;
            m_err    = 0;
         end
      end
      #1;
      if (overrun_err === 1'b1) n_ovr++;
      check("busy", 64'(busy), 64'(m_active));
      check("wr_valid", 64'(wr_valid), 64'(v_exp));
      check("overrun_err", 64'(overrun_err), 64'(ov_exp));
      check("dqs_err", 64'(dqs_err), 64'(m_err));
      if (v_exp || !m_active) check("wr_data", wr_data, m_data);
   endtask

   task automatic idle();
      wr_start = 0;
      dq    = 8'($urandom);
      dqs_t = 1'($urandom);
      dqs_c = 1'($urandom);
      tick();
   endtask

   task automatic burst(input int c, input int bl_raw, input int pre_raw, input int bad_beat,
                        input int ovr_at, input bit post_bad, input int dq_mode, input int reset_at);
      int  p, b, i;
      bit  done;
      logic odd;
      p = (pre_raw == 0) ? 1 : ((pre_raw == 3) ? 2 : pre_raw);
      b = (bl_raw == 4) ? 4 : 8;
      wr_start     = 1;
      cwl          = 5'(c);
      burst_length = 4'(bl_raw);
      preamble     = 2'(pre_raw);
      dq    = 8'($urandom);
      dqs_t = 1'($urandom);
      dqs_c = 1'($urandom);
      tick();
      valid_rel = -1;
      done = 0;
      for (int r = 1; r <= c + p + b + 1 && !done; r++) begin
         wr_start = (r == ovr_at);
         dq = 8'($urandom);
         if (r <= c) begin
            dqs_t = 1'($urandom);
            dqs_c = 1'($urandom);
         end else if (r <= c + p) begin
            dqs_t = 1;
            dqs_c = 0;
         end else if (r <= c + p + b) begin
            i   = r - c - p - 1;
            odd = i[0];
            if (dq_mode == 1) dq = 8'((i + 1) * 17);
            if (dq_mode == 2) dq = 8'(160 + i);
            dqs_t = (i == bad_beat) ? 1'b1 : odd;
            dqs_c = !odd;
         end else begin
            dqs_t = 0;
            dqs_c = !post_bad;
         end
         if (r == reset_at) begin
            reset_n = 0;
            #1;
            check("rst_wr_data", wr_data, 64'h0);
            check("rst_wr_valid", 64'(wr_valid), 64'h0);
            check("rst_busy", 64'(busy), 64'h0);
            check("rst_dqs_err", 64'(dqs_err), 64'h0);
            check("rst_overrun", 64'(overrun_err), 64'h0);
            m_active = 0;
            m_data   = '0;
            m_err    = 0;
            @(posedge CK_t);
            @(posedge CK_t);
            k += 2;
            #1;
            reset_n  = 1;
            wr_start = 0;
            done = 1;
         end else begin
            tick();
            if (wr_valid === 1'b1) valid_rel = r;
         end
      end
      wr_start = 0;
   endtask

   initial begin
      reset_n = 0;
      wr_start = 0;
      cwl = '0;
      burst_length = 4'd8;
      preamble = 2'd1;
      dq = '0;
      dqs_t = 0;
      dqs_c = 1;
      repeat (3) @(posedge CK_t);
      #1;
      check("reset_wr_data", wr_data, 64'h0);
      check("reset_wr_valid", 64'(wr_valid), 64'h0);
      check("reset_busy", 64'(busy), 64'h0);
      check("reset_dqs_err", 64'(dqs_err), 64'h0);
      check("reset_overrun", 64'(overrun_err), 64'h0);
      reset_n = 1;
      idle();
      idle();

      // cwl=5 BL8 preamble 1, beats 0x11..0x88
      burst(5, 8, 1, -1, -1, 0, 1, -1);
      check("t1_valid_edge", 64'(valid_rel), 64'd14);
      check("t1_data", wr_data, 64'h8877665544332211);
      check("t1_dqs_err", 64'(dqs_err), 64'h0);
      check("t1_busy_end", 64'(busy), 64'h0);
      idle();

      // cwl=3 BC4 preamble 2: upper lanes must be cleared
      burst(3, 4, 2, -1, -1, 0, 2, -1);
      check("t2_valid_edge", 64'(valid_rel), 64'd9);
      check("t2_data", wr_data, 64'h00000000A3A2A1A0);
      idle();

      // dqs_t stuck high on beat 2, then back-to-back clean burst clears dqs_err
      burst(2, 8, 1, 2, -1, 0, 0, -1);
      check("t3_dqs_err_set", 64'(dqs_err), 64'h1);
      burst(1, 8, 1, -1, -1, 0, 0, -1);
      check("t3_dqs_err_clr", 64'(dqs_err), 64'h0);
      idle();

      // overlapping wr_start 4 cycles in
      n_ovr = 0;
      burst(3, 8, 1, -1, 4, 0, 1, -1);
      check("t4_ovr_count", 64'(n_ovr), 64'd1);
      check("t4_data", wr_data, 64'h8877665544332211);
      idle();

      // reset during beat 5, then a normal burst
      burst(2, 8, 1, -1, -1, 0, 0, 2 + 1 + 6);
      idle();
      burst(2, 8, 1, -1, -1, 0, 2, -1);
      check("t5_valid_edge", 64'(valid_rel), 64'd11);
      check("t5_data", wr_data, 64'hA7A6A5A4A3A2A1A0);
      idle();

      // cwl=0, burst_length=6, preamble=0 -> BL8, preamble 1
      burst(0, 6, 0, -1, -1, 0, 1, -1);
      check("t6_valid_edge", 64'(valid_rel), 64'd9);
      check("t6_data", wr_data, 64'h8877665544332211);
      idle();

      // postamble error surfaces after the valid pulse
      burst(1, 4, 1, -1, -1, 1, 0, -1);
      check("t7_post_err", 64'(dqs_err), 64'h1);
      idle();

      for (int n = 0; n < 24; n++) begin
         burst($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : -1,
               ($urandom_range(0, 4) == 0), 0, -1);
         repeat ($urandom_range(0, 2)) idle();
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
